// File: rtl/bpu_update_sched_pkg.sv
// rtl/bpu_update_sched_pkg.sv - shared types for the BPU update scheduler
package bpu_update_sched_pkg;

    typedef struct packed {
        logic        flush;
        logic        btb_update;
        logic        lpht_update;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] br_target;
    } bpu_update_t;

    typedef struct packed {
        bpu_update_t upd;
        logic        src;
        logic        valid;
    } bpu_upd_entry_t;

    localparam logic _UPD_SRC_FRONT = 1'b0;
    localparam logic _UPD_SRC_BACK  = 1'b1;

    function automatic logic has_training(input bpu_update_t u);
        return u.btb_update | u.lpht_update;
    endfunction

    function automatic bpu_update_t strip_flush(input bpu_update_t u);
        bpu_update_t r;
        r       = u;
        r.flush = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/bpu_update_sched_if.sv
// rtl/bpu_update_sched_if.sv - update source/sink bundle for the scheduler
interface bpu_update_sched_if
    import bpu_update_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    bpu_update_t                update_front_i;
    bpu_update_t                update_back_i;
    bpu_update_t                update_o;
    logic [$clog2(DEPTH):0]     fifo_cnt_o;
    logic [CNT_W-1:0]           drop_cnt_o;

    modport master (
        output update_front_i,
        output update_back_i,
        input  update_o,
        input  fifo_cnt_o,
        input  drop_cnt_o
    );

    modport slave (
        input  update_front_i,
        input  update_back_i,
        output update_o,
        output fifo_cnt_o,
        output drop_cnt_o
    );
endinterface

// File: rtl/bpu_upd_fifo.sv
// rtl/bpu_upd_fifo.sv - 2-write/1-read training buffer with per-entry valid
// and source-selective squash; squash clears valid bits but never moves pointers.
module bpu_upd_fifo
    import bpu_update_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_a_en,
    input  bpu_upd_entry_t             i_wr_a,
    input  logic                       i_wr_b_en,
    input  bpu_upd_entry_t             i_wr_b,
    input  logic                       i_pop,
    input  logic                       i_squash_front,
    output bpu_upd_entry_t             o_head,
    output logic [$clog2(DEPTH):0]     o_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    bpu_upd_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_cnt;

    logic [PTR_W-1:0]   w_wptr_b;
    logic [PTR_W:0]     w_n_wr;

    // Second write lands after the first; callers only use B together with A.
    assign w_wptr_b = r_wptr + PTR_W'(1);
    assign w_n_wr   = (PTR_W+1)'(i_wr_a_en) + (PTR_W+1)'(i_wr_b_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            if (i_squash_front) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].src == _UPD_SRC_FRONT) begin
                        r_mem[i].valid <= 1'b0;
                    end
                end
            end
            if (i_wr_a_en) begin
                r_mem[r_wptr] <= i_wr_a;
            end
            if (i_wr_b_en) begin
                r_mem[w_wptr_b] <= i_wr_b;
            end
            r_wptr <= r_wptr + w_n_wr[PTR_W-1:0];
            r_rptr <= r_rptr + PTR_W'(i_pop);
            r_cnt  <= r_cnt + w_n_wr - (PTR_W+1)'(i_pop);
        end
    end

    assign o_head = r_mem[r_rptr];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/bpu_update_sched.sv
// rtl/bpu_update_sched.sv - arbitrates front/back branch updates onto the single
// BPU update port: flushes pass through (back wins), training is queued and drained.
module bpu_update_sched
    import bpu_update_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bpu_update_sched_if.slave upd_bus
);
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    bpu_update_t            r_update;
    logic [CNT_W-1:0]       r_drop_cnt;

    bpu_update_t            w_front;
    bpu_update_t            w_back;
    logic                   w_front_f;
    logic                   w_front_t;
    logic                   w_back_f;
    logic                   w_back_t;

    bpu_upd_entry_t         w_head;
    logic [CNT_BITS-1:0]    w_cnt;

    bpu_update_t            w_next_upd;
    logic                   w_pop;
    logic                   w_squash;
    logic                   w_enq_back;
    logic                   w_enq_front;
    logic                   w_grant_back;
    logic                   w_grant_front;
    logic [CNT_BITS:0]      w_free;
    logic [1:0]             w_drops;
    logic [CNT_W:0]         w_drop_sum;
    bpu_upd_entry_t         w_back_ent;
    bpu_upd_entry_t         w_front_ent;
    bpu_upd_entry_t         w_wr_a;

    assign w_front   = upd_bus.update_front_i;
    assign w_back    = upd_bus.update_back_i;
    assign w_front_f = w_front.flush;
    assign w_back_f  = w_back.flush;
    assign w_front_t = has_training(w_front);
    assign w_back_t  = has_training(w_back);

    assign w_back_ent  = '{upd: strip_flush(w_back),  src: _UPD_SRC_BACK,  valid: 1'b1};
    assign w_front_ent = '{upd: strip_flush(w_front), src: _UPD_SRC_FRONT, valid: 1'b1};

    always_comb begin
        w_next_upd  = '0;
        w_pop       = 1'b0;
        w_squash    = 1'b0;
        w_enq_back  = 1'b0;
        w_enq_front = 1'b0;
        if (w_back_f) begin
            // Back redirect makes every queued front hint wrong-path.
            w_next_upd = w_back;
            w_squash   = 1'b1;
        end else if (w_front_f) begin
            w_next_upd = w_front;
            w_enq_back = w_back_t;
        end else if (w_cnt != '0) begin
            w_pop       = 1'b1;
            w_enq_back  = w_back_t;
            w_enq_front = w_front_t;
            if (w_head.valid) begin
                w_next_upd = strip_flush(w_head.upd);
            end
        end else if (w_back_t) begin
            w_next_upd  = w_back;
            w_enq_front = w_front_t;
        end else begin
            w_enq_front = w_front_t;
        end
    end

    // Free slots count the same-cycle pop; back claims a slot before front.
    assign w_free        = (CNT_BITS+1)'(DEPTH) - {1'b0, w_cnt} + (CNT_BITS+1)'(w_pop);
    assign w_grant_back  = w_enq_back && (w_free != '0);
    assign w_grant_front = w_enq_front &&
                           (w_free >= (w_grant_back ? (CNT_BITS+1)'(2) : (CNT_BITS+1)'(1)));
    assign w_drops       = {1'b0, w_enq_back & ~w_grant_back} +
                           {1'b0, w_enq_front & ~w_grant_front};
    assign w_drop_sum    = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drops);
    assign w_wr_a        = w_grant_back ? w_back_ent : w_front_ent;

    bpu_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_wr_a_en      (w_grant_back | w_grant_front),
        .i_wr_a         (w_wr_a),
        .i_wr_b_en      (w_grant_back & w_grant_front),
        .i_wr_b         (w_front_ent),
        .i_pop          (w_pop),
        .i_squash_front (w_squash),
        .o_head         (w_head),
        .o_cnt          (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_update   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_update <= w_next_upd;
            if (w_drop_sum[CNT_W]) begin
                r_drop_cnt <= '1;
            end else begin
                r_drop_cnt <= w_drop_sum[CNT_W-1:0];
            end
        end
    end

    assign upd_bus.update_o   = r_update;
    assign upd_bus.fifo_cnt_o = w_cnt;
    assign upd_bus.drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_bpu_update_sched.sv
// tb/tb_bpu_update_sched.sv - directed vector bench for bpu_update_sched
module tb_bpu_update_sched;
    import bpu_update_sched_pkg::*;

    typedef struct {
        logic        rst;
        bpu_update_t front;
        bpu_update_t back;
        bpu_update_t exp_out;
        int          exp_cnt;
        int          exp_drop;
        int          exp_drop_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    bpu_update_sched_if #(.DEPTH(4), .CNT_W(16)) bus0 ();
    bpu_update_sched_if #(.DEPTH(4), .CNT_W(2))  bus1 ();

    bpu_update_sched #(.DEPTH(4), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .upd_bus (bus0)
    );

    bpu_update_sched #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .upd_bus (bus1)
    );

    always #5 clk = ~clk;

    function automatic bpu_update_t mk_t(input logic [31:0] pc);
        bpu_update_t u = '0;
        u.btb_update = 1'b1;
        u.pc         = pc;
        return u;
    endfunction

    function automatic bpu_update_t mk_f(input logic [31:0] tgt);
        bpu_update_t u = '0;
        u.flush     = 1'b1;
        u.taken     = 1'b1;
        u.br_target = tgt;
        return u;
    endfunction

    task automatic add(input logic r, input bpu_update_t f, input bpu_update_t b,
                       input bpu_update_t eo, input int ec, input int ed, input int eds);
        vec_t v;
        v.rst = r; v.front = f; v.back = b; v.exp_out = eo;
        v.exp_cnt = ec; v.exp_drop = ed; v.exp_drop_sat = eds;
        vecs.push_back(v);
    endtask

    task automatic chk_upd(input string name, input bpu_update_t act, input bpu_update_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input bpu_update_t f, input bpu_update_t b);
        rst                 = r;
        bus0.update_front_i = f;
        bus0.update_back_i  = b;
        bus1.update_front_i = f;
        bus1.update_back_i  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input bpu_update_t eo, input int ec,
                             input int ed, input int eds);
        chk_upd({tag, " update_o"}, bus0.update_o, eo);
        chk_int({tag, " fifo_cnt"}, int'(bus0.fifo_cnt_o), ec);
        chk_int({tag, " drop_cnt"}, int'(bus0.drop_cnt_o), ed);
        chk_upd({tag, " sat update_o"}, bus1.update_o, eo);
        chk_int({tag, " sat drop_cnt"}, int'(bus1.drop_cnt_o), eds);
    endtask

    initial begin
        bpu_update_t z;
        z = '0;

        // reset then idle
        add(1, z, z, z, 0, 0, 0);
        add(1, z, z, z, 0, 0, 0);
        // simultaneous training: back bypasses, front queued
        add(0, mk_t(32'h1c000010), mk_t(32'h1c000020), mk_t(32'h1c000020), 1, 0, 0);
        add(0, z, z, mk_t(32'h1c000010), 0, 0, 0);
        add(0, z, z, z, 0, 0, 0);
        // front-only training on empty FIFO is queued, not bypassed
        add(0, mk_t(32'h1c000030), z, z, 1, 0, 0);
        add(0, z, z, mk_t(32'h1c000030), 0, 0, 0);
        // build mixed queue 54F,68B,58F then back flush squashes front entries
        add(0, mk_t(32'h1c000050), mk_t(32'h1c000060), mk_t(32'h1c000060), 1, 0, 0);
        add(0, mk_t(32'h1c000054), mk_t(32'h1c000064), mk_t(32'h1c000050), 2, 0, 0);
        add(0, mk_t(32'h1c000058), mk_t(32'h1c000068), mk_t(32'h1c000064), 3, 0, 0);
        add(0, mk_t(32'h1c00005c), mk_f(32'h1c000100), mk_f(32'h1c000100), 3, 0, 0);
        add(0, z, z, z, 2, 0, 0);
        add(0, z, z, mk_t(32'h1c000068), 1, 0, 0);
        add(0, z, z, z, 0, 0, 0);
        add(0, z, z, z, 0, 0, 0);
        // front flush with back training
        add(0, mk_f(32'h1c000200), mk_t(32'h1c000040), mk_f(32'h1c000200), 1, 0, 0);
        add(0, z, z, mk_t(32'h1c000040), 0, 0, 0);
        // both flush: back wins
        add(0, mk_f(32'h1c000400), mk_f(32'h1c000500), mk_f(32'h1c000500), 0, 0, 0);
        // overflow: fill with back training under front flushes
        add(0, mk_f(32'h1c000300), mk_t(32'h1c000080), mk_f(32'h1c000300), 1, 0, 0);
        add(0, mk_f(32'h1c000304), mk_t(32'h1c000084), mk_f(32'h1c000304), 2, 0, 0);
        add(0, mk_f(32'h1c000308), mk_t(32'h1c000088), mk_f(32'h1c000308), 3, 0, 0);
        add(0, mk_f(32'h1c00030c), mk_t(32'h1c00008c), mk_f(32'h1c00030c), 4, 0, 0);
        add(0, mk_f(32'h1c000310), mk_t(32'h1c000090), mk_f(32'h1c000310), 4, 1, 1);
        // one slot after pop: back takes it, front dropped
        add(0, mk_t(32'h1c0000a0), mk_t(32'h1c000094), mk_t(32'h1c000080), 4, 2, 2);
        add(0, mk_f(32'h1c000314), mk_t(32'h1c000098), mk_f(32'h1c000314), 4, 3, 3);
        add(0, mk_f(32'h1c000318), mk_t(32'h1c00009c), mk_f(32'h1c000318), 4, 4, 3);
        add(0, z, z, mk_t(32'h1c000084), 3, 4, 3);
        // reset mid-drain
        add(1, z, z, z, 0, 0, 0);
        add(0, z, z, z, 0, 0, 0);
        add(0, z, z, z, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].front, vecs[i].back);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cnt,
                      vecs[i].exp_drop, vecs[i].exp_drop_sat);
        end

        // reset while training is arriving: nothing queued survives
        drive(0, mk_f(32'h1c000600), mk_t(32'h1c0000b0));
        chk_int("pre-rst cnt1", int'(bus0.fifo_cnt_o), 1);
        drive(0, mk_f(32'h1c000604), mk_t(32'h1c0000b4));
        chk_int("pre-rst cnt2", int'(bus0.fifo_cnt_o), 2);
        drive(1, mk_t(32'h1c0000b8), mk_t(32'h1c0000bc));
        check_all("rst-active", z, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, z, z);
            check_all($sformatf("post-rst%0d", k), z, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
